// File: rtl/clk_div_prog_pkg.sv
// Shared clock-generation definitions for the programmable divider: FSM state
// encoding, the smallest legal divisor and divisor arithmetic helpers.
package clk_div_prog_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } clkdiv_state_t;

  localparam int unsigned CLKDIV_MIN_DIV = 2;

  // A divisor below the minimum would leave no low phase, so it is raised to the minimum.
  function automatic int unsigned clkdiv_clamp(input int unsigned n);
    return (n < CLKDIV_MIN_DIV) ? CLKDIV_MIN_DIV : n;
  endfunction

  function automatic int unsigned clkdiv_half(input int unsigned n);
    return (n + 1) >> 1;
  endfunction

endpackage

// File: rtl/clk_div_prog_if.sv
// Control and status bundle of the programmable clock divider.
interface clk_div_prog_if #(
  parameter int unsigned W = 8
);

  logic         enable;
  logic [W-1:0] div_in;
  logic         div_load;
  logic         div_ack;
  logic         busy;
  logic         clk_out;
  logic         tick;

  modport master (
    output enable, div_in, div_load,
    input  div_ack, busy, clk_out, tick
  );

  modport slave (
    input  enable, div_in, div_load,
    output div_ack, busy, clk_out, tick
  );

endinterface

// File: rtl/clk_div_prog.sv
// Programmable integer divider producing a registered divided clock and a tick
// enable; divisor changes, start and stop all take effect on period boundaries.
module clk_div_prog
  import clk_div_prog_pkg::*;
#(
  parameter int unsigned W       = 8,
  parameter int unsigned DEF_DIV = 4
) (
  input logic           clk_in,
  input logic           reset,
  clk_div_prog_if.slave bus
);

  localparam logic [W-1:0] ONE      = W'(1);
  localparam logic [W-1:0] DEF_N    = W'(clkdiv_clamp(DEF_DIV));
  localparam logic [W-1:0] DEF_HALF = W'(clkdiv_half(clkdiv_clamp(DEF_DIV)));

  clkdiv_state_t state_q, state_d;
  logic [W-1:0]  cnt_q, cnt_d;
  logic [W-1:0]  div_act_q, div_act_d;
  logic [W-1:0]  half_q, half_d;
  logic [W-1:0]  div_pend_q, div_pend_d;
  logic          pend_q, pend_d;
  logic          clk_out_q, clk_out_d;
  logic          tick_q, tick_d;
  logic          div_ack_q, div_ack_d;

  logic at_wrap;
  logic apply;

  always_comb begin
    // NOTE: every signal gets a default first so no path through the block leaves it unassigned (no latch).
    state_d    = state_q;
    cnt_d      = cnt_q;
    div_act_d  = div_act_q;
    half_d     = half_q;
    div_pend_d = div_pend_q;
    pend_d     = pend_q;
    div_ack_d  = 1'b0;

    at_wrap = (state_q == RUN) && (cnt_q == div_act_q - ONE);
    apply   = pend_q && (at_wrap || (state_q == IDLE));

    if (apply) begin
      div_act_d = div_pend_q;
      half_d    = W'(clkdiv_half(32'(div_pend_q)));
      pend_d    = 1'b0;
      div_ack_d = 1'b1;
    end

    // A load in the apply cycle re-arms the pending slot after the old value moved on.
    if (bus.div_load) begin
      div_pend_d = W'(clkdiv_clamp(32'(bus.div_in)));
      pend_d     = 1'b1;
    end

    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (bus.enable) state_d = RUN;
      end
      RUN: begin
        if (at_wrap) begin
          cnt_d = '0;
          if (!bus.enable) state_d = IDLE;
        end else begin
          cnt_d = cnt_q + ONE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    // Outputs are derived from next-state values so they register in step with cnt.
    clk_out_d = (state_d == RUN) && (cnt_d < half_d);
    tick_d    = (state_d == RUN) && (cnt_d == '0);
  end

  always_ff @(posedge clk_in) begin
    // NOTE: non-blocking assignments keep every flop sampling pre-edge values regardless of statement order.
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      div_act_q  <= DEF_N;
      half_q     <= DEF_HALF;
      div_pend_q <= DEF_N;
      pend_q     <= 1'b0;
      clk_out_q  <= 1'b0;
      tick_q     <= 1'b0;
      div_ack_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      div_act_q  <= div_act_d;
      half_q     <= half_d;
      div_pend_q <= div_pend_d;
      pend_q     <= pend_d;
      clk_out_q  <= clk_out_d;
      tick_q     <= tick_d;
      div_ack_q  <= div_ack_d;
    end
  end

  assign bus.clk_out = clk_out_q;
  assign bus.tick    = tick_q;
  assign bus.div_ack = div_ack_q;
  assign bus.busy    = pend_q;

endmodule

// File: tb/tb_clk_div_prog.sv
// Directed bench for clk_div_prog: a period-level model checked every cycle,
// plus hand-derived waveform patterns for each scenario.
module tb_clk_div_prog;

  localparam int unsigned W       = 8;
  localparam int unsigned DEF_DIV = 4;

  logic clk_in = 1'b0;
  logic reset;

  clk_div_prog_if #(.W(W)) bus ();

  clk_div_prog #(.W(W), .DEF_DIV(DEF_DIV)) dut (
    .clk_in (clk_in),
    .reset  (reset),
    .bus    (bus)
  );

  always #5 clk_in = ~clk_in;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a running flag, the position inside the current period and the
  // divisor that period uses; clk_out is high for the first ceil(N/2) positions.
  bit m_run, m_pend, m_ack;
  int m_pos, m_n, m_pend_val;

  task automatic model_step(input logic rst, input logic en, input logic ld, input int din);
    bit wrap;
    if (rst) begin
      m_run  = 0;
      m_pos  = 0;
      m_n    = DEF_DIV;
      m_pend = 0;
      m_ack  = 0;
      return;
    end
    wrap  = m_run && (m_pos == m_n - 1);
    m_ack = 0;
    if (m_pend && (wrap || !m_run)) begin
      m_n    = m_pend_val;
      m_pend = 0;
      m_ack  = 1;
    end
    if (ld) begin
      m_pend_val = (din < 2) ? 2 : din;
      m_pend     = 1;
    end
    if (!m_run) begin
      m_pos = 0;
      if (en) m_run = 1;
    end else if (wrap) begin
      m_pos = 0;
      if (!en) m_run = 0;
    end else begin
      m_pos = m_pos + 1;
    end
  endtask

  initial begin
    forever begin
      @(posedge clk_in);
      model_step(reset, bus.enable, bus.div_load, int'(bus.div_in));
      #1;
      check("cyc_clk_out", 32'(bus.clk_out), 32'(m_run && (m_pos < (m_n + 1) / 2)));
      check("cyc_tick",    32'(bus.tick),    32'(m_run && (m_pos == 0)));
      check("cyc_div_ack", 32'(bus.div_ack), 32'(m_ack));
      check("cyc_busy",    32'(bus.busy),    32'(m_pend));
    end
  end

  logic [31:0] cap_clk, cap_tick, cap_ack, cap_busy;

  task automatic capture(input int n);
    cap_clk  = '0;
    cap_tick = '0;
    cap_ack  = '0;
    cap_busy = '0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk_in);
      cap_clk  = {cap_clk[30:0],  bus.clk_out};
      cap_tick = {cap_tick[30:0], bus.tick};
      cap_ack  = {cap_ack[30:0],  bus.div_ack};
      cap_busy = {cap_busy[30:0], bus.busy};
    end
  endtask

  initial begin
    reset        = 1'b1;
    bus.enable   = 1'b0;
    bus.div_load = 1'b0;
    bus.div_in   = '0;
    repeat (3) @(negedge clk_in);
    check("rst_clk_out", 32'(bus.clk_out), 32'd0);
    check("rst_tick",    32'(bus.tick),    32'd0);
    check("rst_busy",    32'(bus.busy),    32'd0);
    check("rst_div_ack", 32'(bus.div_ack), 32'd0);
    reset = 1'b0;
    @(negedge clk_in);
    check("idle_clk_out", 32'(bus.clk_out), 32'd0);

    // Default divisor 4 from the first enabled cycle.
    bus.enable = 1'b1;
    capture(8);
    check("def_clk_pat",  cap_clk,  32'b11001100);
    check("def_tick_pat", cap_tick, 32'b10001000);

    // Load 5 at cnt=1: busy until the wrap, then 11100 periods.
    repeat (2) @(negedge clk_in);
    check("n4_cnt1_clk", 32'(bus.clk_out), 32'd1);
    bus.div_load = 1'b1;
    bus.div_in   = 8'd5;
    @(negedge clk_in);
    bus.div_load = 1'b0;
    check("load5_busy", 32'(bus.busy), 32'd1);
    capture(10);
    check("n5_clk_pat",  cap_clk,  32'b0111001110);
    check("n5_ack_pat",  cap_ack,  32'b0100000000);
    check("n5_busy_pat", cap_busy, 32'b1000000000);

    // Loads of 6 then 3 inside one period: one ack, then 110 periods.
    repeat (2) @(negedge clk_in);
    check("n5_cnt0_tick", 32'(bus.tick), 32'd1);
    bus.div_load = 1'b1;
    bus.div_in   = 8'd6;
    @(negedge clk_in);
    bus.div_in   = 8'd3;
    @(negedge clk_in);
    bus.div_load = 1'b0;
    capture(12);
    check("n3_clk_pat",  cap_clk,  32'b001101101101);
    check("n3_tick_pat", cap_tick, 32'b001001001001);
    check("n3_ack_pat",  cap_ack,  32'b001000000000);
    check("n3_busy_pat", cap_busy, 32'b110000000000);

    // Loads of 0 and 1 clamp to 2; the last load coincides with the apply.
    bus.div_load = 1'b1;
    bus.div_in   = 8'd0;
    @(negedge clk_in);
    bus.div_in   = 8'd1;
    @(negedge clk_in);
    @(negedge clk_in);
    bus.div_load = 1'b0;
    check("coinc_ack",  32'(bus.div_ack), 32'd1);
    check("coinc_busy", 32'(bus.busy),    32'd1);
    capture(6);
    check("n2_clk_pat",  cap_clk,  32'b010101);
    check("n2_ack_pat",  cap_ack,  32'b010000);
    check("n2_busy_pat", cap_busy, 32'b100000);

    // Back to 4, drop enable at cnt=1, then re-enable.
    bus.div_load = 1'b1;
    bus.div_in   = 8'd4;
    @(negedge clk_in);
    bus.div_load = 1'b0;
    @(negedge clk_in);
    check("n4_ack", 32'(bus.div_ack), 32'd1);
    @(negedge clk_in);
    check("stop_cnt1_clk", 32'(bus.clk_out), 32'd1);
    bus.enable = 1'b0;
    capture(6);
    check("stop_clk_pat",  cap_clk,  32'b000000);
    check("stop_tick_pat", cap_tick, 32'b000000);
    bus.enable = 1'b1;
    capture(5);
    check("restart_clk_pat",  cap_clk,  32'b11001);
    check("restart_tick_pat", cap_tick, 32'b10001);

    // Reset with a load pending: pending value discarded, divisor back to default.
    bus.div_load = 1'b1;
    bus.div_in   = 8'd7;
    @(negedge clk_in);
    bus.div_load = 1'b0;
    check("pre_rst_busy", 32'(bus.busy), 32'd1);
    reset = 1'b1;
    @(negedge clk_in);
    check("mid_rst_clk_out", 32'(bus.clk_out), 32'd0);
    check("mid_rst_tick",    32'(bus.tick),    32'd0);
    check("mid_rst_busy",    32'(bus.busy),    32'd0);
    check("mid_rst_div_ack", 32'(bus.div_ack), 32'd0);
    reset = 1'b0;
    capture(8);
    check("post_rst_clk_pat",  cap_clk,  32'b11001100);
    check("post_rst_busy_pat", cap_busy, 32'b00000000);
    check("post_rst_ack_pat",  cap_ack,  32'b00000000);

    // Apply in IDLE together with enable rising: first period already uses 3.
    bus.enable = 1'b0;
    @(negedge clk_in);
    check("idle2_clk_out", 32'(bus.clk_out), 32'd0);
    bus.div_load = 1'b1;
    bus.div_in   = 8'd3;
    @(negedge clk_in);
    check("idle_load_busy", 32'(bus.busy), 32'd1);
    bus.div_load = 1'b0;
    bus.enable   = 1'b1;
    capture(6);
    check("idle_apply_clk_pat",  cap_clk,  32'b110110);
    check("idle_apply_tick_pat", cap_tick, 32'b100100);
    check("idle_apply_ack_pat",  cap_ack,  32'b100000);

    @(negedge clk_in);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
